imm_field_encoder: RTL and testbench

//  Inverse of the sign-extension path: packs a 64-bit immediate into the

---
 rtl/imm_field_encoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_imm_field_encoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_field_encoder.sv
// imm_field_encoder
//   Packs a 64-bit immediate into the Instruction[25:0] field layouts used by
//   the decoder (I, D, CB, B). It can also turn an arbitrary 64-bit constant
//   into a MOVZ word followed by MOVK words. Every request produces one or
//   more output words, and each word is held until the consumer accepts it.
//
//   Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that are
//   out of range, misaligned, or carry an illegal Op. The flag is raised on
//   RangeErr and the field is still emitted, truncated. Without the macro,
//   RangeErr is tied low and fields are silently truncated.
//
//   SKIP_ZERO_HW = 1: emit a MOVK only for nonzero higher halfwords.
//   SKIP_ZERO_HW = 0: emit every halfword above the MOVZ halfword.
module imm_field_encoder #(
  parameter int SKIP_ZERO_HW = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [2:0]  Op,
  input  logic [63:0] Value,
  input  logic [4:0]  Rd,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [25:0] Field,
  output logic        OutIsMovz,
  output logic        OutIsMovk,
  output logic        OutLast,
  output logic        RangeErr
);

  localparam logic [2:0] OP_I   = 3'd0;
  localparam logic [2:0] OP_D   = 3'd1;
  localparam logic [2:0] OP_CB  = 3'd2;
  localparam logic [2:0] OP_B   = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  // Architectural state; every output port is driven straight from a register
  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [25:0] field_q;
  logic        movz_q;
  logic        movk_q;
  logic        last_q;
  logic        err_q;
  logic [63:0] value_q;   // constant latched at accept, walked halfword by halfword
  logic [4:0]  rd_q;
  logic [1:0]  hw_q;      // halfword index of the word currently presented

  // First word of a request, computed from the live request inputs
  logic [25:0] first_field_d;
  logic        first_movz_d;
  logic        first_movk_d;
  logic        first_last_d;
  logic        first_err_d;
  logic [1:0]  first_hw_d;
  logic [3:0]  in_nz;
  logic [2:0]  first_nx;

  // Next MOVK word of a sequence, computed from the latched constant
  logic [3:0]  held_nz;
  logic [2:0]  step_nx;
  logic [2:0]  step_nx2;
  logic [1:0]  step_hw_d;
  logic [25:0] step_field_d;
  logic        step_last_d;

  // One bit per halfword: set when that halfword is nonzero
  function automatic logic [3:0] hw_nonzero(input logic [63:0] v);
    return {|v[63:48], |v[47:32], |v[31:16], |v[15:0]};
  endfunction

  function automatic logic [15:0] hw_slice(input logic [63:0] v, input logic [1:0] hw);
    logic [15:0] r;
    case (hw)
      2'd0:    r = v[15:0];
      2'd1:    r = v[31:16];
      2'd2:    r = v[47:32];
      default: r = v[63:48];
    endcase
    return r;
  endfunction

  // MOVZ/MOVK layout: hw in [22:21], halfword in [20:5], Rd in [4:0]
  function automatic logic [25:0] mov_field(input logic [63:0] v, input logic [1:0] hw,
                                            input logic [4:0] rd);
    return {3'b000, hw, hw_slice(v, hw), rd};
  endfunction

  // Lowest nonzero halfword. Returns 0 when the whole constant is zero.
  function automatic logic [1:0] lowest_nz(input logic [3:0] nz);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (nz[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Halfword that follows cur in the sequence, as {found, hw}
  function automatic logic [2:0] next_hw(input logic [3:0] nz, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    if (SKIP_ZERO_HW != 0) begin
      // Scan downwards so that the lowest qualifying halfword wins
      for (int i = 3; i >= 0; i--) begin
        if (i > int'(cur) && nz[i]) r = {1'b1, 2'(i)};
      end
    end else if (cur != 2'd3) begin
      r = {1'b1, cur + 2'd1};
    end
    return r;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  // Flag an immediate that is out of range for its encoding, misaligned, or
  // carries an illegal Op. A value is in range when every bit above the
  // field's sign bit equals that sign bit.
  function automatic logic range_err(input logic [2:0] op, input logic [63:0] v);
    logic r;
    case (op)
      OP_I:    r = !((&v[63:11]) || !(|v[63:11]));
      OP_D:    r = !((&v[63:8])  || !(|v[63:8]));
      OP_CB:   r = !((&v[63:20]) || !(|v[63:20])) || (v[1:0] != 2'b00);
      OP_B:    r = !((&v[63:27]) || !(|v[63:27])) || (v[1:0] != 2'b00);
      OP_MOV:  r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction
`endif

  // First output word of the request presented on the inputs
  // NOTE: every signal assigned in this block gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    first_field_d = '0;
    first_movz_d  = 1'b0;
    first_movk_d  = 1'b0;
    first_last_d  = 1'b1;
    first_err_d   = 1'b0;
    first_hw_d    = 2'd0;
    in_nz         = hw_nonzero(Value);
    first_nx      = 3'b000;
    case (Op)
      OP_I:  first_field_d[21:10] = Value[11:0];
      OP_D:  first_field_d[20:12] = Value[8:0];
      OP_CB: first_field_d[23:5]  = Value[20:2];
      OP_B:  first_field_d[25:0]  = Value[27:2];
      OP_MOV: begin
        first_hw_d    = lowest_nz(in_nz);
        first_nx      = next_hw(in_nz, first_hw_d);
        first_field_d = mov_field(Value, first_hw_d, Rd);
        first_movz_d  = 1'b1;
        // A zero constant is always a single MOVZ, whatever SKIP_ZERO_HW is
        first_last_d  = (in_nz == 4'b0000) || !first_nx[2];
      end
      default: first_field_d = '0;
    endcase
`ifdef IMM_RANGE_CHECK_EN
    first_err_d = range_err(Op, Value);
`endif
  end

  // Next MOVK word, derived from the latched constant and the current halfword
  always_comb begin
    held_nz      = hw_nonzero(value_q);
    step_nx      = next_hw(held_nz, hw_q);
    step_hw_d    = step_nx[1:0];
    step_nx2     = next_hw(held_nz, step_hw_d);
    step_field_d = mov_field(value_q, step_hw_d, rd_q);
    step_last_d  = !step_nx2[2];
  end

  // Request/emit FSM; all outputs are registered and held while stalled
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      field_q     <= '0;
      movz_q      <= 1'b0;
      movk_q      <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      value_q     <= '0;
      rd_q        <= '0;
      hw_q        <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (InValid && in_ready_q) begin
            value_q     <= Value;
            rd_q        <= Rd;
            hw_q        <= first_hw_d;
            field_q     <= first_field_d;
            movz_q      <= first_movz_d;
            movk_q      <= first_movk_d;
            last_q      <= first_last_d;
            err_q       <= first_err_d;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (OutReady) begin
            if (last_q) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              hw_q    <= step_hw_d;
              field_q <= step_field_d;
              movz_q  <= 1'b0;
              movk_q  <= 1'b1;
              last_q  <= step_last_d;
              err_q   <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign InReady   = in_ready_q;
  assign OutValid  = out_valid_q;
  assign Field     = field_q;
  assign OutIsMovz = movz_q;
  assign OutIsMovk = movk_q;
  assign OutLast   = last_q;
  assign RangeErr  = err_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Testbench for imm_field_encoder: randomized requests are scored against a
// behavioural model of the field layouts; a monitor pops expected words as
// the DUT hands them over.
`timescale 1ns/1ps
module tb_imm_field_encoder;

  localparam int SKIP = 1;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [2:0]  Op = '0;
  logic [63:0] Value = '0;
  logic [4:0]  Rd = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [25:0] Field;
  logic        OutIsMovz;
  logic        OutIsMovk;
  logic        OutLast;
  logic        RangeErr;

  typedef struct packed {
    logic [25:0] field;
    logic        movz;
    logic        movk;
    logic        last;
    logic        err;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ready_mode = 1;   // 0: hold OutReady low, 1: hold high, 2: random
  bit    mon_en = 1'b1;

  imm_field_encoder #(.SKIP_ZERO_HW(SKIP)) dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Op(Op), .Value(Value), .Rd(Rd),
    .OutValid(OutValid), .OutReady(OutReady), .Field(Field),
    .OutIsMovz(OutIsMovz), .OutIsMovk(OutIsMovk), .OutLast(OutLast),
    .RangeErr(RangeErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint op_lim(input logic [2:0] op);
    case (op)
      3'd0:    return 64'sd2048;
      3'd1:    return 64'sd256;
      3'd2:    return 64'sd1 << 20;
      3'd3:    return 64'sd1 << 27;
      default: return 64'sd2048;
    endcase
  endfunction

  function automatic longint op_step(input logic [2:0] op);
    return (op == 3'd2 || op == 3'd3) ? 64'sd4 : 64'sd1;
  endfunction

  task automatic model_push(input logic [2:0] op, input logic [63:0] v, input logic [4:0] rd);
    word_t       w;
    longint      s;
    logic [63:0] f;
    int          hws[$];
    s = longint'(v);
    w = '0;
    w.last = 1'b1;
    if (op <= 3'd3) begin
      case (op)
        3'd0:    f = (v & 64'hFFF) << 10;
        3'd1:    f = (v & 64'h1FF) << 12;
        3'd2:    f = ((v >> 2) & 64'h7FFFF) << 5;
        default: f = (v >> 2) & 64'h3FF_FFFF;
      endcase
      w.field = f[25:0];
`ifdef IMM_RANGE_CHECK_EN
      w.err = (s < -op_lim(op)) || (s > op_lim(op) - op_step(op)) ||
              (op_step(op) == 4 && (v & 64'd3) != 0);
`endif
      exp_q.push_back(w);
    end else if (op == 3'd4) begin
      for (int h = 0; h < 4; h++)
        if (((v >> (16 * h)) & 64'hFFFF) != 0) hws.push_back(h);
      if (hws.size() == 0) hws.push_back(0);
      else if (SKIP == 0) begin
        for (int h = hws[0] + 1; h < 4; h++) if (hws[hws.size()-1] < h) hws.push_back(h);
      end
      foreach (hws[i]) begin
        w = '0;
        w.movz = (i == 0);
        w.movk = (i != 0);
        w.last = (i == hws.size() - 1);
        f = (64'(hws[i]) << 21) | (((v >> (16 * hws[i])) & 64'hFFFF) << 5) | 64'(rd);
        w.field = f[25:0];
        exp_q.push_back(w);
      end
    end else begin
`ifdef IMM_RANGE_CHECK_EN
      w.err = 1'b1;
`endif
      exp_q.push_back(w);
    end
    if (s == 0) w = '0;  // keeps s referenced in builds without range checking
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] rand_value(input logic [2:0] op);
    longint      lim;
    longint      st;
    longint      s;
    logic [63:0] v;
    lim = op_lim(op);
    st  = op_step(op);
    case ($urandom_range(0, 4))
      0: v = {$urandom, $urandom};
      1: begin
        s = longint'($urandom_range(0, 32'(4 * lim - 1))) - 2 * lim;
        if (st == 4 && $urandom_range(0, 3) != 0) s = s & ~64'sd3;
        v = 64'(s);
      end
      2: begin
        case ($urandom_range(0, 4))
          0:       s = -lim;
          1:       s = lim - st;
          2:       s = lim;
          3:       s = -lim - st;
          default: s = lim - 2;
        endcase
        v = 64'(s);
      end
      3: begin
        v = {$urandom, $urandom};
        for (int h = 0; h < 4; h++) if ($urandom_range(0, 1) == 1) v[16*h +: 16] = '0;
      end
      default: v = 64'($urandom_range(0, 15));
    endcase
    return v;
  endfunction

  task automatic send(input logic [2:0] op, input logic [63:0] v, input logic [4:0] rd);
    int g;
    g = 0;
    @(negedge CLK);
    InValid = 1'b1;
    Op = op;
    Value = v;
    Rd = rd;
    while (!InReady && g < 200) begin
      @(negedge CLK);
      g++;
    end
    if (!InReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: InReady=0 after 200 cycles, required 1");
      InValid = 1'b0;
      return;
    end
    model_push(op, v, rd);
    @(posedge CLK);
    #1;
    // Scramble the inputs: the DUT must work from the latched request
    InValid = 1'b0;
    Op = 3'($urandom);
    Value = {$urandom, $urandom};
    Rd = 5'($urandom);
    @(negedge CLK);
    check("accept_latency_outvalid", 64'(OutValid), 64'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || OutValid) && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
    end
    @(negedge CLK);
  endtask

  // OutReady driver
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       OutReady = 1'b0;
        1:       OutReady = 1'b1;
        default: OutReady = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  word_t cur_w;
  word_t held_w;
  word_t exp_w;
  bit    stalled_prev = 1'b0;
  bit    chk_idle_next = 1'b0;

  always @(negedge CLK) begin
    cur_w = {Field, OutIsMovz, OutIsMovk, OutLast, RangeErr};
    if (!mon_en || Reset) begin
      stalled_prev  = 1'b0;
      chk_idle_next = 1'b0;
    end else begin
      if (chk_idle_next) begin
        check("idle_after_last_inready_outvalid", 64'({InReady, OutValid}), 64'd2);
        chk_idle_next = 1'b0;
      end
      if (OutValid) begin
        check("inready_low_while_busy", 64'(InReady), 64'd0);
        if (stalled_prev) check("hold_while_stalled", 64'(cur_w), 64'(held_w));
        if (OutReady) begin
          stalled_prev = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got field 0x%0h, expected no word", Field);
          end else begin
            exp_w = exp_q.pop_front();
            check("field", 64'(cur_w.field), 64'(exp_w.field));
            check("flags_movz_movk_last_err",
                  64'({cur_w.movz, cur_w.movk, cur_w.last, cur_w.err}),
                  64'({exp_w.movz, exp_w.movk, exp_w.last, exp_w.err}));
          end
          if (OutLast) chk_idle_next = 1'b1;
        end else begin
          stalled_prev = 1'b1;
          held_w = cur_w;
        end
      end else begin
        stalled_prev = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] op;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_inready", 64'(InReady), 64'd1);
    check("reset_outvalid", 64'(OutValid), 64'd0);
    check("reset_field", 64'(Field), 64'd0);
    check("reset_flags", 64'({OutIsMovz, OutIsMovk, OutLast, RangeErr}), 64'd0);
    Reset = 1'b0;

    // Directed cases, consumer always ready
    ready_mode = 1;
    send(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0);
    send(3'd4, 64'h0000_1234_0000_ABCD, 5'd3);
    send(3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0);
    send(3'd2, 64'd6, 5'd0);
    send(3'd4, 64'd0, 5'd7);
    send(3'd0, 64'd2047, 5'd0);
    send(3'd0, 64'd2048, 5'd0);
    send(3'd1, 64'hFFFF_FFFF_FFFF_FF00, 5'd0);
    send(3'd1, 64'd256, 5'd0);
    send(3'd2, 64'h0000_0000_000F_FFFC, 5'd0);
    send(3'd3, 64'h0000_0000_07FF_FFFC, 5'd0);
    send(3'd3, 64'h0000_0000_0800_0000, 5'd0);
    send(3'd3, 64'hFFFF_FFFF_F800_0000, 5'd0);
    send(3'd5, 64'h1234, 5'd9);
    send(3'd7, 64'hFFFF, 5'd9);
    send(3'd4, 64'hFFFF_0000_0000_0000, 5'd31);
    drain();

    // Consumer stalls for three cycles on the first word of a MOVCONST
    ready_mode = 0;
    send(3'd4, 64'h0000_1234_0000_ABCD, 5'd3);
    repeat (3) @(negedge CLK);
    check("stall_first_word_field", 64'(Field), 64'h1579A3);
    check("stall_first_word_flags", 64'({OutValid, OutIsMovz, OutLast}), 64'd6);
    ready_mode = 1;
    drain();

    // Randomized traffic with a randomly stalling consumer
    ready_mode = 2;
    repeat (300) begin
      op = 3'($urandom_range(0, 9) > 7 ? 4 : $urandom_range(0, 7));
      send(op, rand_value(op), 5'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    ready_mode = 1;
    drain();

    // Reset while the second word of a 4-word MOVCONST is presented
    mon_en = 1'b0;
    send(3'd4, 64'h1111_2222_3333_4444, 5'd1);
    exp_q.delete();
    @(negedge CLK);
    check("rst_seq_second_word", 64'(Field), 64'h266661);
    Reset = 1'b1;
    @(negedge CLK);
    check("rst_seq_outvalid", 64'(OutValid), 64'd0);
    check("rst_seq_inready", 64'(InReady), 64'd1);
    check("rst_seq_field", 64'(Field), 64'd0);
    check("rst_seq_flags", 64'({OutIsMovz, OutIsMovk, OutLast, RangeErr}), 64'd0);
    Reset = 1'b0;
    mon_en = 1'b1;
    send(3'd1, 64'd5, 5'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
